// File: rtl/trace_drain.sv
`default_nettype none
// ============================================================================
//  Module   : trace_drain
//  Purpose  : Queues full N-element trace vectors arriving on a valid-only
//             push interface and streams them out one element per cycle on a
//             valid/ready interface toward the host readout path. Marks the
//             final element of end-of-frame vectors and flags dropped vectors.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             valid_in, eof_in,
//             vector_in             - vector push (no backpressure besides
//                                     ready_out; pushes while full are dropped)
//             ready_out             - queue not full (from registered count)
//             out_valid, out_ready,
//             out_data, out_index,
//             out_last              - element stream to the host
//             count                 - vectors stored, including the one draining
//             overflow              - sticky: at least one vector was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module trace_drain #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic                           eof_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    output logic                           ready_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(N)-1:0]           out_index,
    output logic                           out_last,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] c_IDX_ONE  = IW'(1);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] c_FULL     = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_EMPTY     = 1'b0,
        ST_SERIALIZE = 1'b1
    } state_t;

    // Slot storage: payload and end-of-frame flag per queued vector
    logic [N-1:0][DATA_WIDTH-1:0] r_slot_data [DEPTH];
    logic                         r_slot_eof  [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [IW-1:0] r_elem_idx;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    state_t        r_state;
    state_t        w_state_next;

    logic          w_push;
    logic          w_pop;
    logic          w_beat;
    logic [CW-1:0] w_count_next;

    // Full is judged on the registered count only, so a same-cycle pop
    // never opens a slot for the incoming vector.
    assign ready_out = (r_count != c_FULL);
    assign out_valid = (r_state == ST_SERIALIZE);
    assign w_push    = valid_in && ready_out;
    assign w_beat    = out_valid && out_ready;
    assign w_pop     = w_beat && (r_elem_idx == c_LAST_IDX);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Next state follows the post-update occupancy, which gives both the
    // one-cycle push-to-valid latency and bubble-free back-to-back vectors.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY:     if (w_count_next != '0) w_state_next = ST_SERIALIZE;
            ST_SERIALIZE: if (w_count_next == '0) w_state_next = ST_EMPTY;
            default:      w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_elem_idx <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (valid_in && !ready_out) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_elem_idx <= '0;
            end else if (w_beat) begin
                r_elem_idx <= r_elem_idx + c_IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_data[i] <= '0;
                r_slot_eof[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_slot_data[r_wr_ptr] <= vector_in;
            r_slot_eof[r_wr_ptr]  <= eof_in;
        end
    end

    // Element outputs are pure functions of registered state, so they hold
    // automatically while the downstream stalls.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = r_slot_data[r_rd_ptr][r_elem_idx];
        end
    end

    assign out_index = r_elem_idx;
    assign out_last  = out_valid && r_slot_eof[r_rd_ptr] && (r_elem_idx == c_LAST_IDX);
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_trace_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_drain
//  Purpose  : Self-checking bench for trace_drain (N=8, DATA_WIDTH=32,
//             DEPTH=4). A cycle table covers single-vector streaming and
//             backpressure; hand-written sequences cover overflow, pop/push
//             at full, pointer wrap-around and reset in mid-drain.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trace_drain;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int DP = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   valid_in;
    logic                   eof_in;
    logic [N-1:0][DW-1:0]   vector_in;
    logic                   ready_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [2:0]             out_index;
    logic                   out_last;
    logic [2:0]             count;
    logic                   overflow;

    int checks;
    int failures;

    trace_drain #(.N(N), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .eof_in    (eof_in),
        .vector_in (vector_in),
        .ready_out (ready_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element e of vector 'tag' carries {tag, e} so order errors are visible
    function automatic logic [DW-1:0] elem(input int tag, input int e);
        return DW'(tag * 65536 + e);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, settle 1 time unit
    task automatic step(input bit vin, input bit eof, input int tag, input bit ordy);
        valid_in  = vin;
        eof_in    = eof;
        out_ready = ordy;
        for (int e = 0; e < N; e++) vector_in[e] = elem(tag, e);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        eof_in    = 1'b0;
        out_ready = 1'b0;
        vector_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_count",     DW'(count),     0);
        chk("rst_overflow",  DW'(overflow),  0);
        chk("rst_ready_out", DW'(ready_out), 1);
        chk("rst_out_index", DW'(out_index), 0);
        chk("rst_out_last",  DW'(out_last),  0);
        chk("rst_out_data",  out_data,       0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          vin;
        bit          eof;
        int          tag;
        bit          ordy;
        bit          ev;
        logic [31:0] ed;
        int          ei;
        bit          el;
        int          ec;
        bit          er;
    } vec_t;

    function automatic vec_t row(bit vin, bit eof, int tag, bit ordy, bit ev,
                                 logic [31:0] ed, int ei, bit el, int ec, bit er);
        vec_t r;
        r.vin = vin; r.eof = eof; r.tag = tag; r.ordy = ordy;
        r.ev = ev; r.ed = ed; r.ei = ei; r.el = el; r.ec = ec; r.er = er;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        checks   = 0;
        failures = 0;

        // ---- table: single eof vector, then a non-eof vector with a stall
        tbl.push_back(row(1, 1, 0, 1, 1, elem(0, 0), 0, 0, 1, 1));
        for (int e = 1; e < N; e++)
            tbl.push_back(row(0, 0, 0, 1, 1, elem(0, e), e, e == N - 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(row(1, 0, 1, 1, 1, elem(1, 0), 0, 0, 1, 1));
        tbl.push_back(row(0, 0, 0, 1, 1, elem(1, 1), 1, 0, 1, 1));
        tbl.push_back(row(0, 0, 0, 1, 1, elem(1, 2), 2, 0, 1, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(row(0, 0, 0, 0, 1, elem(1, 2), 2, 0, 1, 1));
        for (int e = 3; e < N; e++)
            tbl.push_back(row(0, 0, 0, 1, 1, elem(1, e), e, 0, 1, 1));
        tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vin, tbl[i].eof, tbl[i].tag, tbl[i].ordy);
            chk($sformatf("tbl%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
                chk($sformatf("tbl%0d_out_last", i), DW'(out_last), DW'(tbl[i].el));
            end
            chk($sformatf("tbl%0d_out_index", i), DW'(out_index), DW'(tbl[i].ei));
            chk($sformatf("tbl%0d_count", i),     DW'(count),     DW'(tbl[i].ec));
            chk($sformatf("tbl%0d_ready_out", i), DW'(ready_out), DW'(tbl[i].er));
        end

        // ---- full / overflow: 5 pushes with the output stalled
        chk("ovf_initial", DW'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            step(1, k == 3, 2 + k, 0);
            chk($sformatf("ovf_count_%0d", k), DW'(count), DW'(k + 1));
            chk($sformatf("ovf_ready_%0d", k), DW'(ready_out), DW'(k < 3));
        end
        step(1, 1, 6, 0);
        chk("ovf_flag",       DW'(overflow), 1);
        chk("ovf_count_full", DW'(count),    4);
        step(0, 0, 0, 0);
        chk("ovf_sticky", DW'(overflow), 1);
        for (int v = 0; v < 4; v++) begin
            for (int e = 0; e < N; e++) begin
                chk($sformatf("ovf_drain_v%0d_e%0d", v, e), out_data, elem(2 + v, e));
                chk($sformatf("ovf_last_v%0d_e%0d", v, e), DW'(out_last), DW'(v == 3 && e == N - 1));
                step(0, 0, 0, 1);
            end
        end
        chk("ovf_end_valid",  DW'(out_valid), 0);
        chk("ovf_end_count",  DW'(count),     0);
        chk("ovf_end_sticky", DW'(overflow),  1);

        // ---- push at full on the same edge as the head vector pops
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 7 + k, 0);
        chk("simul_full", DW'(ready_out), 0);
        for (int k = 0; k < N - 1; k++) step(0, 0, 0, 1);
        chk("simul_idx7", DW'(out_index), 7);
        step(1, 0, 11, 1);
        chk("simul_count",    DW'(count),     3);
        chk("simul_overflow", DW'(overflow),  1);
        chk("simul_ready",    DW'(ready_out), 1);
        for (int v = 0; v < 3; v++) begin
            for (int e = 0; e < N; e++) begin
                chk($sformatf("simul_drain_v%0d_e%0d", v, e), out_data, elem(8 + v, e));
                step(0, 0, 0, 1);
            end
        end
        chk("simul_end_valid", DW'(out_valid), 0);

        // ---- wrap-around: 10 vectors, one push every N cycles
        do_reset();
        for (int c = 0; c < 10 * N; c++) begin
            step((c % N) == 0, 0, 20 + c / N, 1);
            chk($sformatf("wrap_valid_c%0d", c), DW'(out_valid), 1);
            chk($sformatf("wrap_data_c%0d", c),  out_data, elem(20 + c / N, c % N));
            chk($sformatf("wrap_idx_c%0d", c),   DW'(out_index), DW'(c % N));
            chk($sformatf("wrap_count_c%0d", c), DW'(count), 1);
        end
        step(0, 0, 0, 1);
        chk("wrap_end_valid", DW'(out_valid), 0);
        chk("wrap_end_count", DW'(count),     0);

        // ---- reset in mid-drain
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 40 + k, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1);
        chk("mid_idx5",  DW'(out_index), 5);
        chk("mid_count", DW'(count),     3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", DW'(out_valid), 0);
        chk("mid_rst_count", DW'(count),     0);
        chk("mid_rst_ready", DW'(ready_out), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 1, 50, 1);
        for (int e = 0; e < N; e++) begin
            chk($sformatf("post_rst_data_e%0d", e), out_data, elem(50, e));
            chk($sformatf("post_rst_idx_e%0d", e),  DW'(out_index), DW'(e));
            step(0, 0, 0, 1);
        end
        chk("post_rst_end_valid", DW'(out_valid), 0);
        chk("post_rst_overflow",  DW'(overflow),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_drain.md
# trace_drain

Read-side counterpart of the vector input buffer: accepts full N-element trace vectors on a valid-only push interface and streams them out one DATA_WIDTH element per cycle on a valid/ready interface toward the host readout path. It holds up to DEPTH vectors in a circular register queue. It marks the final element of an end-of-frame vector, and flags vectors dropped on overflow. It sits at the tail of the tracing pipeline, between the reduction/filter stages and the narrow host link.

## Interface
- N, 8, elements per vector (≥2)
- DATA_WIDTH, 32, bits per element
- DEPTH, 4, vector slots in queue (power of two, ≥2)

Clock and reset are decided: one clock; reset is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  vector_in/eof_in valid this cycle
- eof_in  in  1  vector is last of frame
- vector_in  in  DATA_WIDTH × [N-1:0]  input vector
- ready_out  out  1  queue not full (combinational: count != DEPTH)
- out_valid  out  1  out_data holds an element
- out_ready  in  1  downstream accepts element
- out_data  out  DATA_WIDTH  current element
- out_index  out  $clog2(N)  element index within head vector
- out_last  out  1  eof vector AND out_index==N-1
- count  out  $clog2(DEPTH)+1  vectors stored, including the one being drained
- overflow  out  1  sticky: a vector was dropped

## Operation
- Storage: DEPTH slots of {eof, N×DATA_WIDTH}, write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1→0 naturally.
- Push: valid_in && ready_out → slot[wr_ptr] ← {eof_in, vector_in}, wr_ptr+1.
- Drop: valid_in && !ready_out → vector discarded, overflow ← 1. There is no bypass: the block refuses a write when full even if a pop occurs in the same cycle.
- State machine, two states:
  - EMPTY: out_valid=0. Moves to SERIALIZE when count becomes nonzero.
  - SERIALIZE: out_valid=1.
- In SERIALIZE:
  - out_data = slot[rd_ptr].element[elem_idx], and out_index = elem_idx.
  - Element 0 is sent first.
  - On out_valid && out_ready with elem_idx<N-1: elem_idx+1.
  - On out_valid && out_ready with elem_idx==N-1: pop the vector (rd_ptr+1, elem_idx←0). Stay in SERIALIZE if the post-update count is nonzero, otherwise go to EMPTY.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Back-to-back vectors: after a pop, the next vector's element 0 is presented in the immediately following cycle, with no bubble.
- out_data, out_index and out_last hold stable while out_valid && !out_ready.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.

## Timing
- Reset (asynchronous assert):
  - out_valid=0, count=0, overflow=0, ready_out=1.
  - out_index=0, out_last=0, out_data=0.
  - Pointers and elem_idx are 0; state is EMPTY.
  - Slot contents are cleared to 0.
- Reset mid-drain: the partially sent vector and all queued vectors are lost; out_valid falls immediately, asynchronously.
- Latency: a vector pushed at edge k gives out_valid=1 with element 0 after edge k, i.e. visible in cycle k+1.
- Throughput: 1 element/cycle with out_ready held high, so one vector per N cycles.
- ready_out depends only on registered count. It has no combinational path from out_ready.
- A pop completing at edge k frees a slot, so ready_out=1 in cycle k+1.

## Test plan
- Single vector: N=8, push {0..7} with eof=1; hold out_ready=1 → out_data 0,1,…,7 on 8 consecutive cycles starting 1 cycle after the push, out_last=1 only on element 7, then out_valid=0 and count=0.
- Backpressure: drop out_ready for 3 cycles while elem_idx=2 → out_data stays at element 2 and out_index stays at 2; the stream resumes at 3 with no loss or duplicate.
- Full/overflow: DEPTH=4, out_ready=0, push 5 vectors → ready_out=0 after the 4th push, count=4; the 5th vector is dropped, overflow=1 and stays 1. Drain all → vectors 1–4 appear in order.
- Wrap-around: push and drain 10 vectors with out_ready=1 and a new push every N cycles → all 80 elements appear in order; pointers wrap twice; count never exceeds 2.
- Simultaneous push+pop at full: with count=4, push on the same cycle the last element of the head vector is accepted → push is dropped (overflow=1), count goes to 3.
- Reset mid-drain: assert rst_n=0 at elem_idx=5 with 3 vectors queued → out_valid=0 and count=0 immediately. After release, pushing a new vector gives its element 0 first, with none of the old data.
